adc_spi_reader_multi: RTL and testbench

//  Parametrised successor of the single-channel AD7687 reader. It starts conversions on N_CH
//  AD7687-class SAR ADCs that share CNV and SCK, each with its own SDO line.
//  It reads DATA_W bits MSB-first from all channels in parallel and presents one aligned word set

---
 rtl/adc_spi_reader_multi.sv | 192 +++++++++++++++++++
 tb/tb_adc_spi_reader_multi.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_reader_multi.sv
// Multi-channel AD7687-class SAR ADC reader.
// Shared CNV/SCK, per-channel SDO, parallel MSB-first capture.
module adc_spi_reader_multi #(
    parameter int DATA_W   = 16,
    parameter int N_CH     = 2,
    parameter int SCK_DIV  = 2,
    parameter int T_CONV   = 30,
    parameter int USE_BUSY = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     START,
    input  logic                     FREE_RUN,
    input  logic [N_CH-1:0]          DATA_IN,
    output logic                     CNV,
    output logic                     SCK,
    output logic [N_CH*DATA_W-1:0]   DATA_OUT,
    output logic                     VALID,
    output logic                     BUSY,
    output logic                     TIMEOUT_ERR,
    output logic [15:0]              CONV_CNT
);

    localparam int TCW = $clog2(T_CONV + 1);
    localparam int TOW = $clog2(TIMEOUT + 1);
    localparam int DVW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int BTW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT,
        S_SHIFT,
        S_LATCH
    } state_t;

    state_t                   r_state;
    state_t                   w_next;
    logic [TCW-1:0]           r_tcnt;
    logic [TOW-1:0]           r_wcnt;
    logic [DVW-1:0]           r_div;
    logic [BTW-1:0]           r_bit;
    logic                     r_low;
    logic                     r_cnv;
    logic                     r_sck;
    logic                     r_valid;
    logic                     r_busy;
    logic                     r_terr;
    logic [15:0]              r_conv_cnt;
    logic [N_CH*DATA_W-1:0]   r_dout;
    logic [DATA_W-1:0]        r_sreg [N_CH];

    logic                     w_sck_nxt;
    logic                     w_rise;
    logic                     w_timeout;
    logic                     w_half_end;

    // Next state, SCK phase and shift/timeout strobes.
    always_comb begin
        w_next     = r_state;
        w_sck_nxt  = 1'b1;
        w_rise     = 1'b0;
        w_timeout  = 1'b0;
        w_half_end = (r_div == DVW'(SCK_DIV - 1));
        unique case (r_state)
            S_IDLE: begin
                if (START || FREE_RUN) begin
                    w_next = S_CONV;
                end
            end
            S_CONV: begin
                if (r_tcnt == TCW'(T_CONV - 1)) begin
                    w_next = (USE_BUSY != 0) ? S_WAIT : S_SHIFT;
                end
            end
            S_WAIT: begin
                if (!DATA_IN[0] && r_low) begin
                    w_next = S_SHIFT;
                end else if (r_wcnt == TOW'(TIMEOUT - 1)) begin
                    w_next    = S_IDLE;
                    w_timeout = 1'b1;
                end
            end
            S_SHIFT: begin
                w_sck_nxt = r_sck;
                if (w_half_end) begin
                    if (!r_sck) begin
                        w_sck_nxt = 1'b1;
                        w_rise    = 1'b1;
                    end else if (r_bit == BTW'(DATA_W - 1)) begin
                        w_next = S_LATCH;
                    end else begin
                        w_sck_nxt = 1'b0;
                    end
                end
            end
            S_LATCH: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        // First half-period of the shift phase is SCK low.
        if (w_next == S_SHIFT && r_state != S_SHIFT) begin
            w_sck_nxt = 1'b0;
        end
    end

    // State register and phase counters.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_tcnt  <= '0;
            r_wcnt  <= '0;
            r_div   <= '0;
            r_bit   <= '0;
            r_low   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_tcnt  <= (r_state == S_CONV) ? r_tcnt + 1'b1 : '0;
            r_wcnt  <= (r_state == S_WAIT) ? r_wcnt + 1'b1 : '0;
            r_low   <= (r_state == S_WAIT) ? !DATA_IN[0] : 1'b0;
            if (r_state == S_SHIFT) begin
                r_div <= w_half_end ? '0 : r_div + 1'b1;
                if (w_half_end && r_sck) begin
                    r_bit <= r_bit + 1'b1;
                end
            end else begin
                r_div <= '0;
                r_bit <= '0;
            end
        end
    end

    // Per-channel shift registers, clocked on the SCK rising edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int c = 0; c < N_CH; c++) begin
                r_sreg[c] <= '0;
            end
        end else if (w_rise) begin
            for (int c = 0; c < N_CH; c++) begin
                r_sreg[c] <= {r_sreg[c][DATA_W-2:0], DATA_IN[c]};
            end
        end
    end

    // Registered pin outputs decoded from the next state.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_cnv   <= 1'b0;
            r_sck   <= 1'b1;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_cnv   <= (w_next == S_CONV);
            r_sck   <= w_sck_nxt;
            r_valid <= (w_next == S_LATCH);
            r_busy  <= (w_next != S_IDLE);
        end
    end

    // Result word, conversion counter and sticky timeout flag.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_dout     <= '0;
            r_conv_cnt <= '0;
            r_terr     <= 1'b0;
        end else begin
            if (w_next == S_LATCH) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_dout[c*DATA_W +: DATA_W] <= r_sreg[c];
                end
                r_conv_cnt <= r_conv_cnt + 16'd1;
                r_terr     <= 1'b0;
            end else if (w_timeout) begin
                r_terr <= 1'b1;
            end
        end
    end

    assign CNV         = r_cnv;
    assign SCK         = r_sck;
    assign VALID       = r_valid;
    assign BUSY        = r_busy;
    assign DATA_OUT    = r_dout;
    assign CONV_CNT    = r_conv_cnt;
    assign TIMEOUT_ERR = r_terr;

endmodule

// File: tb/tb_adc_spi_reader_multi.sv
// Directed bench for adc_spi_reader_multi.
// Two instances: fixed conversion time, and busy-wait with short timeout.
module tb_adc_spi_reader_multi;

    localparam int DW = 16;
    localparam int NC = 2;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic RESET;
    logic START_a, FR_a, START_b, FR_b;
    logic [NC-1:0] din_a, din_b, DATA_IN_b;
    logic CNV_a, SCK_a, VALID_a, BUSY_a, TE_a;
    logic CNV_b, SCK_b, VALID_b, BUSY_b, TE_b;
    logic [NC*DW-1:0] DOUT_a, DOUT_b;
    logic [15:0] CNT_a, CNT_b;

    logic [DW-1:0] word_a [NC];
    logic [DW-1:0] word_b [NC];
    int k_a = 0;
    int k_b = 0;
    logic sp_a = 1'b1;
    logic sp_b = 1'b1;
    logic ovr_en = 1'b0;
    logic ovr_val = 1'b1;

    int checks = 0;
    int errors = 0;

    assign DATA_IN_b = {din_b[1], ovr_en ? ovr_val : din_b[0]};

    adc_spi_reader_multi #(
        .DATA_W(16), .N_CH(2), .SCK_DIV(2), .T_CONV(30),
        .USE_BUSY(0), .TIMEOUT(255)
    ) dut_a (
        .CLK(CLK), .RESET(RESET), .START(START_a), .FREE_RUN(FR_a),
        .DATA_IN(din_a), .CNV(CNV_a), .SCK(SCK_a), .DATA_OUT(DOUT_a),
        .VALID(VALID_a), .BUSY(BUSY_a), .TIMEOUT_ERR(TE_a),
        .CONV_CNT(CNT_a)
    );

    adc_spi_reader_multi #(
        .DATA_W(16), .N_CH(2), .SCK_DIV(2), .T_CONV(30),
        .USE_BUSY(1), .TIMEOUT(20)
    ) dut_b (
        .CLK(CLK), .RESET(RESET), .START(START_b), .FREE_RUN(FR_b),
        .DATA_IN(DATA_IN_b), .CNV(CNV_b), .SCK(SCK_b), .DATA_OUT(DOUT_b),
        .VALID(VALID_b), .BUSY(BUSY_b), .TIMEOUT_ERR(TE_b),
        .CONV_CNT(CNT_b)
    );

    // ADC models: MSB after CNV, next bit after each SCK rise.
    always @(negedge CLK) begin
        if (CNV_a) k_a = 0;
        else if (SCK_a && !sp_a) k_a = k_a + 1;
        sp_a = SCK_a;
        for (int c = 0; c < NC; c++)
            din_a[c] = (k_a < DW) ? word_a[c][DW-1-k_a] : 1'b0;
    end

    always @(negedge CLK) begin
        if (CNV_b) k_b = 0;
        else if (SCK_b && !sp_b) k_b = k_b + 1;
        sp_b = SCK_b;
        for (int c = 0; c < NC; c++)
            din_b[c] = (k_b < DW) ? word_b[c][DW-1-k_b] : 1'b0;
    end

    task automatic test_reset();
        RESET = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (CNV_a !== 1'b0 || SCK_a !== 1'b1 || VALID_a !== 1'b0 ||
            BUSY_a !== 1'b0 || TE_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: cnv=%b sck=%b vld=%b bsy=%b te=%b want 0 1 0 0 0",
                     CNV_a, SCK_a, VALID_a, BUSY_a, TE_a);
        end
        checks++;
        if (DOUT_a !== 32'h0 || CNT_a !== 16'h0 || TE_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: dout=%h cnt=%h te_b=%b want 0 0 0",
                     DOUT_a, CNT_a, TE_b);
        end
        RESET = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_single();
        int vobs, nval, cf, cl, cn, lows, lmin, lmax, run;
        logic [31:0] dout;
        logic [15:0] cnt;
        logic bz1, bz96;
        vobs = 0; nval = 0; cf = 0; cl = 0; cn = 0;
        lows = 0; lmin = 999; lmax = 0; run = 0;
        dout = '0; cnt = '0; bz1 = 1'b0; bz96 = 1'b1;
        word_a[0] = 16'hA5C3;
        word_a[1] = 16'h0001;
        @(negedge CLK) START_a = 1'b1;
        for (int n = 1; n <= 130; n++) begin
            @(negedge CLK);
            START_a = 1'b0;
            if (CNV_a) begin
                cn++;
                if (cf == 0) cf = n;
                cl = n;
            end
            if (VALID_a) begin
                nval++; vobs = n; dout = DOUT_a; cnt = CNT_a;
            end
            if (!SCK_a) run++;
            else if (run > 0) begin
                lows++;
                if (run < lmin) lmin = run;
                if (run > lmax) lmax = run;
                run = 0;
            end
            if (n == 1) bz1 = BUSY_a;
            if (n == 96) bz96 = BUSY_a;
        end
        checks++;
        if (cf != 1 || cl != 30 || cn != 30) begin
            errors++;
            $display("FAIL t1_cnv: first=%0d last=%0d n=%0d want 1 30 30", cf, cl, cn);
        end
        checks++;
        if (vobs != 95 || nval != 1) begin
            errors++;
            $display("FAIL t1_valid: cycle=%0d count=%0d want 95 1", vobs, nval);
        end
        checks++;
        if (dout !== 32'h0001_A5C3) begin
            errors++;
            $display("FAIL t1_data: got %h want 0001a5c3", dout);
        end
        checks++;
        if (cnt !== 16'd1) begin
            errors++;
            $display("FAIL t1_cnt: got %0d want 1", cnt);
        end
        checks++;
        if (lows != 16 || lmin != 2 || lmax != 2) begin
            errors++;
            $display("FAIL t1_sck: pulses=%0d min=%0d max=%0d want 16 2 2",
                     lows, lmin, lmax);
        end
        checks++;
        if (bz1 !== 1'b1 || bz96 !== 1'b0) begin
            errors++;
            $display("FAIL t1_busy: c1=%b c96=%b want 1 0", bz1, bz96);
        end
        checks++;
        if (DOUT_a !== 32'h0001_A5C3) begin
            errors++;
            $display("FAIL t1_hold: got %h want 0001a5c3", DOUT_a);
        end
    endtask

    task automatic test_free_run();
        logic [15:0] w0 [3];
        logic [15:0] w1 [3];
        int vt [3];
        logic [31:0] dv [3];
        logic [15:0] cv [3];
        int nval, rises, gap, gmin;
        logic pc;
        w0[0] = 16'h0000; w0[1] = 16'hFFFF; w0[2] = 16'h8000;
        w1[0] = 16'h1234; w1[1] = 16'hEDCB; w1[2] = 16'h0F00;
        nval = 0; rises = 0; gap = 0; gmin = 9999; pc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vt[i] = 0; dv[i] = '0; cv[i] = '0;
        end
        @(negedge CLK) FR_a = 1'b1;
        for (int n = 1; n <= 400; n++) begin
            @(negedge CLK);
            if (CNV_a && !pc) begin
                if (rises > 0 && gap < gmin) gmin = gap;
                if (rises < 3) begin
                    word_a[0] = w0[rises];
                    word_a[1] = w1[rises];
                end
                rises++;
                if (rises == 3) FR_a = 1'b0;
            end
            if (!CNV_a) gap++;
            else gap = 0;
            pc = CNV_a;
            if (VALID_a) begin
                if (nval < 3) begin
                    vt[nval] = n; dv[nval] = DOUT_a; cv[nval] = CNT_a;
                end
                nval++;
            end
        end
        checks++;
        if (nval != 3 || rises != 3) begin
            errors++;
            $display("FAIL t2_count: valids=%0d starts=%0d want 3 3", nval, rises);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (vt[i] != 95 + 96 * i || dv[i] !== {w1[i], w0[i]} ||
                cv[i] !== 16'(2 + i)) begin
                errors++;
                $display("FAIL t2_conv%0d: cyc=%0d data=%h cnt=%0d want %0d %h %0d",
                         i, vt[i], dv[i], cv[i], 95 + 96 * i, {w1[i], w0[i]}, 2 + i);
            end
        end
        checks++;
        if (gmin < 66) begin
            errors++;
            $display("FAIL t2_gap: cnv low gap=%0d want >=66", gmin);
        end
    endtask

    task automatic test_reset_mid_shift();
        int vobs, nval;
        logic [31:0] dout;
        logic [15:0] cnt;
        vobs = 0; nval = 0; dout = '0; cnt = '0;
        word_a[0] = 16'h5A5A;
        word_a[1] = 16'hC001;
        @(negedge CLK) START_a = 1'b1;
        for (int n = 1; n < 60; n++) begin
            @(negedge CLK);
            START_a = 1'b0;
        end
        RESET = 1'b0;
        #1;
        checks++;
        if (CNV_a !== 1'b0 || SCK_a !== 1'b1 || VALID_a !== 1'b0 ||
            BUSY_a !== 1'b0) begin
            errors++;
            $display("FAIL t5_ctrl: cnv=%b sck=%b vld=%b bsy=%b want 0 1 0 0",
                     CNV_a, SCK_a, VALID_a, BUSY_a);
        end
        checks++;
        if (DOUT_a !== 32'h0 || CNT_a !== 16'h0) begin
            errors++;
            $display("FAIL t5_data: dout=%h cnt=%h want 0 0", DOUT_a, CNT_a);
        end
        @(negedge CLK) RESET = 1'b1;
        @(negedge CLK) START_a = 1'b1;
        for (int n = 1; n <= 110; n++) begin
            @(negedge CLK);
            START_a = 1'b0;
            if (VALID_a) begin
                nval++; vobs = n; dout = DOUT_a; cnt = CNT_a;
            end
        end
        checks++;
        if (vobs != 95 || nval != 1 || dout !== 32'hC001_5A5A || cnt !== 16'd1) begin
            errors++;
            $display("FAIL t5_after: cyc=%0d n=%0d data=%h cnt=%0d want 95 1 c0015a5a 1",
                     vobs, nval, dout, cnt);
        end
    endtask

    task automatic test_start_ignored_wrap();
        int vobs, nval, rises;
        logic [31:0] dout;
        logic [15:0] cnt;
        logic pc, bz;
        vobs = 0; nval = 0; rises = 0; dout = '0; cnt = 16'h5555;
        pc = 1'b0; bz = 1'b1;
        word_a[0] = 16'h1357;
        word_a[1] = 16'h2468;
        @(negedge CLK);
        force dut_a.r_conv_cnt = 16'hFFFF;
        #1 release dut_a.r_conv_cnt;
        @(negedge CLK) START_a = 1'b1;
        for (int n = 1; n <= 200; n++) begin
            @(negedge CLK);
            START_a = (n == 10 || n == 50) ? 1'b1 : 1'b0;
            if (CNV_a && !pc) rises++;
            pc = CNV_a;
            if (VALID_a) begin
                nval++; vobs = n; dout = DOUT_a; cnt = CNT_a;
            end
            if (n == 200) bz = BUSY_a;
        end
        checks++;
        if (rises != 1 || nval != 1 || bz !== 1'b0) begin
            errors++;
            $display("FAIL t6_ignore: starts=%0d valids=%0d busy=%b want 1 1 0",
                     rises, nval, bz);
        end
        checks++;
        if (vobs != 95 || dout !== 32'h2468_1357) begin
            errors++;
            $display("FAIL t6_data: cyc=%0d data=%h want 95 24681357", vobs, dout);
        end
        checks++;
        if (cnt !== 16'h0000) begin
            errors++;
            $display("FAIL t6_wrap: cnt=%h want 0000", cnt);
        end
    endtask

    task automatic test_busy_timeout();
        int tf, nval, vobs;
        logic bz, te1, tev;
        logic [31:0] dout;
        logic [15:0] cnt;
        tf = 0; nval = 0; vobs = 0; bz = 1'b1; te1 = 1'b0; tev = 1'b1;
        dout = '0; cnt = '0;
        word_b[0] = 16'h3C96;
        word_b[1] = 16'h8001;
        ovr_en = 1'b1;
        ovr_val = 1'b1;
        @(negedge CLK) START_b = 1'b1;
        for (int n = 1; n <= 80; n++) begin
            @(negedge CLK);
            START_b = 1'b0;
            if (TE_b && tf == 0) tf = n;
            if (VALID_b) nval++;
            if (n == 52) bz = BUSY_b;
        end
        checks++;
        if (tf != 51 || nval != 0 || bz !== 1'b0) begin
            errors++;
            $display("FAIL t3_timeout: te_cyc=%0d valids=%0d busy=%b want 51 0 0",
                     tf, nval, bz);
        end
        checks++;
        if (CNT_b !== 16'd0 || DOUT_b !== 32'h0) begin
            errors++;
            $display("FAIL t3_nochange: cnt=%0d dout=%h want 0 0", CNT_b, DOUT_b);
        end
        nval = 0;
        ovr_val = 1'b0;
        @(negedge CLK) START_b = 1'b1;
        for (int n = 1; n <= 130; n++) begin
            @(negedge CLK);
            START_b = 1'b0;
            if (ovr_en && !SCK_b) ovr_en = 1'b0;
            if (n == 1) te1 = TE_b;
            if (VALID_b) begin
                nval++; vobs = n; dout = DOUT_b; cnt = CNT_b; tev = TE_b;
            end
        end
        checks++;
        if (te1 !== 1'b1 || tev !== 1'b0) begin
            errors++;
            $display("FAIL t3_sticky: te_start=%b te_valid=%b want 1 0", te1, tev);
        end
        checks++;
        if (vobs != 97 || nval != 1 || dout !== 32'h8001_3C96 || cnt !== 16'd1) begin
            errors++;
            $display("FAIL t3_good: cyc=%0d n=%0d data=%h cnt=%0d want 97 1 80013c96 1",
                     vobs, nval, dout, cnt);
        end
    endtask

    task automatic test_busy_glitch();
        int sf, nval, vobs;
        logic [31:0] dout;
        logic [15:0] cnt;
        sf = 0; nval = 0; vobs = 0; dout = '0; cnt = '0;
        word_b[0] = 16'h7E11;
        word_b[1] = 16'h0F0F;
        ovr_en = 1'b1;
        ovr_val = 1'b1;
        @(negedge CLK) START_b = 1'b1;
        for (int n = 1; n <= 140; n++) begin
            @(negedge CLK);
            START_b = 1'b0;
            if (n == 35) ovr_val = 1'b0;
            if (n == 36) ovr_val = 1'b1;
            if (n == 40) ovr_val = 1'b0;
            if (ovr_en && !SCK_b) begin
                ovr_en = 1'b0;
                sf = n;
            end
            if (VALID_b) begin
                nval++; vobs = n; dout = DOUT_b; cnt = CNT_b;
            end
        end
        checks++;
        if (sf != 42) begin
            errors++;
            $display("FAIL t4_shift_start: first sck low=%0d want 42", sf);
        end
        checks++;
        if (vobs != 106 || nval != 1 || dout !== 32'h0F0F_7E11 || cnt !== 16'd2) begin
            errors++;
            $display("FAIL t4_data: cyc=%0d n=%0d data=%h cnt=%0d want 106 1 0f0f7e11 2",
                     vobs, nval, dout, cnt);
        end
    endtask

    initial begin
        RESET = 1'b0;
        START_a = 1'b0; FR_a = 1'b0;
        START_b = 1'b0; FR_b = 1'b0;
        for (int c = 0; c < NC; c++) begin
            word_a[c] = '0;
            word_b[c] = '0;
        end
        test_reset();
        test_single();
        test_free_run();
        test_reset_mid_shift();
        test_start_ignored_wrap();
        test_busy_timeout();
        test_busy_glitch();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
